// File: rtl/div_unit_pkg.sv
// Shared constants and state encoding for the iterative integer divider.
package div_unit_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned ITER_D = 64;
  localparam int unsigned ITER_W = 32;
  localparam int unsigned CNT_W  = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the divider.
interface div_unit_if;
  import div_unit_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic            op_signed;
  logic            op_word;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  modport master (
    output in_valid, op_signed, op_word, dividend, divisor, flush, out_ready,
    input  in_ready, out_valid, quotient, remainder
  );

  modport slave (
    input  in_valid, op_signed, op_word, dividend, divisor, flush, out_ready,
    output in_ready, out_valid, quotient, remainder
  );

endinterface

// File: rtl/div_unit_step.sv
// One restoring shift-subtract iteration: produces one quotient bit.
module div_step
  import div_unit_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dsr,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          ge;

  // Shift in the next dividend bit and try subtracting the divisor.
  // Since rem < dsr, a non-negative difference always fits in XLEN bits,
  // so the top bit of diff is a clean borrow flag.
  always_comb begin
    shifted  = {rem, quo[XLEN-1]};
    diff     = shifted - {1'b0, dsr};
    ge       = ~diff[XLEN];
    rem_next = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_next = {quo[XLEN-2:0], ge};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 divider for RV64 DIV/DIVU/REM/REMU and W variants.
module div_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);
  import div_unit_pkg::*;

  localparam int unsigned HALF = XLEN / 2;
  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [HALF-1:0] MIN_W = {1'b1, {(HALF-1){1'b0}}};

  state_e state_q, state_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;

  logic [XLEN-1:0]  rem_q, quo_q, dsr_q;
  logic [XLEN-1:0]  quotient_q, remainder_q;
  logic [CNT_W-1:0] cnt_q;
  logic             word_q, neg_quo_q, neg_rem_q;

  logic [HALF-1:0] a_lo, b_lo, a_mag32, b_mag32;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] a_load, b_load, a_sext, spec_q, spec_r;
  logic            div_zero, overflow, special, accept;

  logic [CNT_W-1:0] n_iter;
  logic             last;
  logic [XLEN-1:0]  rem_step, quo_step;
  logic [HALF-1:0]  q32, r32;
  logic [XLEN-1:0]  q_fix, r_fix;

  // Operand magnitudes, sign flags and special-case detection for the request.
  always_comb begin
    a_lo     = bus.dividend[HALF-1:0];
    b_lo     = bus.divisor[HALF-1:0];
    sign_a   = 1'b0;
    sign_b   = 1'b0;
    a_mag32  = '0;
    b_mag32  = '0;
    a_load   = '0;
    b_load   = '0;
    a_sext   = bus.dividend;
    div_zero = 1'b0;
    overflow = 1'b0;
    if (bus.op_word) begin
      sign_a   = bus.op_signed & a_lo[HALF-1];
      sign_b   = bus.op_signed & b_lo[HALF-1];
      a_mag32  = sign_a ? HALF'(0) - a_lo : a_lo;
      b_mag32  = sign_b ? HALF'(0) - b_lo : b_lo;
      // The word dividend sits in the upper half so it shifts out first.
      a_load   = {a_mag32, HALF'(0)};
      b_load   = {HALF'(0), b_mag32};
      a_sext   = {{HALF{a_lo[HALF-1]}}, a_lo};
      div_zero = (b_lo == '0);
      overflow = bus.op_signed & (a_lo == MIN_W) & (b_lo == '1);
    end else begin
      sign_a   = bus.op_signed & bus.dividend[XLEN-1];
      sign_b   = bus.op_signed & bus.divisor[XLEN-1];
      a_load   = sign_a ? XLEN'(0) - bus.dividend : bus.dividend;
      b_load   = sign_b ? XLEN'(0) - bus.divisor : bus.divisor;
      div_zero = (bus.divisor == '0);
      overflow = bus.op_signed & (bus.dividend == MIN_D) & (bus.divisor == '1);
    end
    special = div_zero | overflow;
    spec_q  = div_zero ? '1 : a_sext;
    spec_r  = div_zero ? a_sext : '0;
    accept  = (state_q == IDLE) & bus.in_valid & ~bus.flush;
  end

  div_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dsr      (dsr_q),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  // Iteration bound and sign fix-up of the final magnitudes.
  always_comb begin
    n_iter = word_q ? CNT_W'(ITER_W) : CNT_W'(ITER_D);
    last   = (cnt_q == n_iter);
    q32    = '0;
    r32    = '0;
    if (word_q) begin
      q32   = neg_quo_q ? HALF'(0) - quo_q[HALF-1:0] : quo_q[HALF-1:0];
      r32   = neg_rem_q ? HALF'(0) - rem_q[HALF-1:0] : rem_q[HALF-1:0];
      q_fix = {{HALF{q32[HALF-1]}}, q32};
      r_fix = {{HALF{r32[HALF-1]}}, r32};
    end else begin
      q_fix = neg_quo_q ? XLEN'(0) - quo_q : quo_q;
      r_fix = neg_rem_q ? XLEN'(0) - rem_q : rem_q;
    end
  end

  // State register plus registered handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic; flush wins over acceptance and completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!bus.flush && bus.in_valid) state_d = special ? DONE : BUSY;
      BUSY: begin
        if (bus.flush)  state_d = IDLE;
        else if (last)  state_d = DONE;
      end
      DONE: if (bus.flush || bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags decoded from the next state so they register with it.
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // Datapath: latch operands, iterate, and publish results on DONE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      cnt_q       <= '0;
      word_q      <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else if (accept) begin
      rem_q     <= '0;
      quo_q     <= a_load;
      dsr_q     <= b_load;
      cnt_q     <= '0;
      word_q    <= bus.op_word;
      neg_quo_q <= sign_a ^ sign_b;
      neg_rem_q <= sign_a;
      if (special) begin
        quotient_q  <= spec_q;
        remainder_q <= spec_r;
      end
    end else if (state_q == BUSY && !bus.flush) begin
      if (last) begin
        quotient_q  <= q_fix;
        remainder_q <= r_fix;
      end else begin
        rem_q <= rem_step;
        quo_q <= quo_step;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors, random ops, control paths.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] last_q, last_r;

  div_unit_if bus ();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
  } vec_t;

  // Reference result from the architectural definition of the instructions.
  function automatic void model(input logic sgn, input logic word,
                                input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] q, output logic [63:0] r,
                                output int lat);
    logic [31:0] a32, b32, q32, r32;
    int     sa, sb;
    longint la, lb;
    a32 = a[31:0];
    b32 = b[31:0];
    if (word) begin
      if (b32 == 32'd0) begin
        q = '1; r = {{32{a32[31]}}, a32}; lat = 0;
      end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q = {{32{a32[31]}}, a32}; r = '0; lat = 0;
      end else begin
        if (sgn) begin
          sa = a32; sb = b32;
          q32 = 32'(sa / sb); r32 = 32'(sa % sb);
        end else begin
          q32 = a32 / b32; r32 = a32 % b32;
        end
        q = {{32{q32[31]}}, q32}; r = {{32{r32[31]}}, r32}; lat = 33;
      end
    end else begin
      if (b == 64'd0) begin
        q = '1; r = a; lat = 0;
      end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = '0; lat = 0;
      end else begin
        if (sgn) begin
          la = a; lb = b;
          q = 64'(la / lb); r = 64'(la % lb);
        end else begin
          q = a / b; r = a % b;
        end
        lat = 65;
      end
    end
  endfunction

  // Present one request, then count edges until out_valid (bounded).
  task automatic run_op(input logic sgn, input logic word,
                        input logic [63:0] a, input logic [63:0] b,
                        output int lat, output logic [63:0] q, output logic [63:0] r);
    bus.op_signed = sgn;
    bus.op_word   = word;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    q = bus.quotient;
    r = bus.remainder;
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++;
    if (bus.quotient !== 64'd0 || bus.remainder !== 64'd0) begin
      errors++; $display("FAIL reset_results got q=%h r=%h want 0/0", bus.quotient, bus.remainder);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    vec_t v[7];
    int lat;
    logic [63:0] q, r;
    v[0] = '{1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65};
    v[1] = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    v[2] = '{1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65};
    v[3] = '{1'b0, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 0};
    v[4] = '{1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0, 0};
    v[5] = '{1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'd0, 0};
    v[6] = '{1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 64'd1, 33};
    for (int i = 0; i < 7; i++) begin
      run_op(v[i].sgn, v[i].word, v[i].a, v[i].b, lat, q, r);
      checks++;
      if (lat !== v[i].lat) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, v[i].lat); end
      checks++;
      if (q !== v[i].q) begin errors++; $display("FAIL dir%0d_quotient got %h want %h", i, q, v[i].q); end
      checks++;
      if (r !== v[i].r) begin errors++; $display("FAIL dir%0d_remainder got %h want %h", i, r, v[i].r); end
      release_out();
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL dir%0d_release got in_ready=%b out_valid=%b want 1/0", i, bus.in_ready, bus.out_valid);
      end
      last_q = v[i].q;
      last_r = v[i].r;
    end
  endtask

  task automatic test_random();
    int lat, elat;
    logic sgn, word;
    logic [63:0] a, b, q, r, eq, er;
    for (int i = 0; i < 40; i++) begin
      sgn  = 1'($urandom_range(0, 1));
      word = 1'($urandom_range(0, 1));
      a    = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = {$urandom, 32'd0};
        1: b = '1;
        2: b = {$urandom, 32'd0} | 64'($urandom_range(1, 20));
        3: b = {$urandom, $urandom};
        4: b = {32'd0, $urandom};
        default: begin
          b = {$urandom, $urandom};
          a = word ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
        end
      endcase
      model(sgn, word, a, b, eq, er, elat);
      run_op(sgn, word, a, b, lat, q, r);
      checks++;
      if (lat !== elat || q !== eq || r !== er) begin
        errors++;
        $display("FAIL rand%0d s=%b w=%b a=%h b=%h got lat=%0d q=%h r=%h want lat=%0d q=%h r=%h",
                 i, sgn, word, a, b, lat, q, r, elat, eq, er);
      end
      release_out();
      last_q = eq;
      last_r = er;
    end
  endtask

  task automatic test_hold();
    int lat, bad;
    logic [63:0] q, r;
    run_op(1'b0, 1'b0, 64'd100, 64'd7, lat, q, r);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.quotient !== 64'd14 || bus.remainder !== 64'd2) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hold_stable got %0d unstable cycles want 0", bad); end
    // A request offered on the retiring edge must not be taken.
    bus.dividend  = 64'd9;
    bus.divisor   = 64'd0;
    bus.op_signed = 1'b0;
    bus.op_word   = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL hold_retire got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    last_q = 64'd14;
    last_r = 64'd2;
  endtask

  task automatic test_flush();
    int seen;
    bus.op_signed = 1'b0;
    bus.op_word   = 1'b0;
    bus.dividend  = 64'd1000;
    bus.divisor   = 64'd3;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_busy got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL flush_no_result got %0d valid cycles want 0", seen); end
    checks++;
    if (bus.quotient !== last_q || bus.remainder !== last_r) begin
      errors++; $display("FAIL flush_results_kept got q=%h r=%h want %h/%h", bus.quotient, bus.remainder, last_q, last_r);
    end
    // Flush coincident with a request blocks acceptance.
    bus.divisor  = 64'd0;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_accept got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    // Flush in DONE drops the pending result.
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.quotient !== '1 || bus.remainder !== 64'd1000) begin
      errors++; $display("FAIL flush_done_setup got v=%b q=%h r=%h want 1/ffffffffffffffff/3e8",
                         bus.out_valid, bus.quotient, bus.remainder);
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_done got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_rst_mid();
    int seen;
    bus.op_signed = 1'b1;
    bus.op_word   = 1'b0;
    bus.dividend  = 64'hFFFF_FFFF_FFFF_FF00;
    bus.divisor   = 64'd7;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus.quotient !== 64'd0 || bus.remainder !== 64'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid got q=%h r=%h v=%b rdy=%b want 0/0/0/1",
                         bus.quotient, bus.remainder, bus.out_valid, bus.in_ready);
    end
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rst_mid_no_result got %0d valid cycles want 0", seen); end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op_signed = 1'b0;
    bus.op_word   = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    last_q        = '0;
    last_r        = '0;
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_flush();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: XLEN, default 64, datapath width; only 64 is supported.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  execute stage presents a divide request.
REQ-005 in_ready  output  1  unit can accept a request; high only in IDLE.
REQ-006 op_signed  input  1  1 = DIV/REM semantics, 0 = DIVU/REMU.
REQ-007 op_word  input  1  1 = RV64 W-variant: operate on bits [31:0].
REQ-008 dividend  input  XLEN  numerator operand.
REQ-009 divisor  input  XLEN  denominator operand.
REQ-010 flush  input  1  abort any operation in flight (pipeline redirect).
REQ-011 out_valid  output  1  quotient/remainder valid; held until accepted.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 quotient  output  XLEN  result quotient.
REQ-014 remainder  output  XLEN  result remainder.

Function
REQ-015 States SHALL be IDLE, BUSY, DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-016 A request SHALL be accepted on a rising edge where in_valid && in_ready && !flush; operands and op bits are latched at that edge.
REQ-017 Normal requests SHALL use a restoring radix-2 shift-subtract, one quotient bit per cycle: 64 iterations (XLEN), or 32 iterations when op_word=1.
REQ-018 Latency: accepted at edge T, out_valid SHALL rise after edge T+N+1 (N = 64 or 32), i.e. IDLE -> BUSY at T, BUSY -> DONE after the N-th iteration edge.
REQ-019 Signed ops SHALL divide magnitudes; quotient negated iff operand signs differ, remainder takes the dividend's sign (round toward zero).
REQ-020 Divide by zero SHALL bypass BUSY (IDLE -> DONE at T): quotient = all ones, remainder = dividend (word: sign-extended dividend[31:0]).
REQ-021 Signed overflow (most-negative / -1, at the active width) SHALL bypass BUSY: quotient = dividend, remainder = 0.
REQ-022 op_word=1 SHALL use only operand bits [31:0] (sign-interpreted if op_signed) and sign-extend both 32-bit results to 64 bits, for signed and unsigned alike.
REQ-023 DONE SHALL hold quotient/remainder stable until out_ready=1; DONE -> IDLE on that edge; no new request is accepted in the same cycle.
REQ-024 flush=1 SHALL force IDLE on the next edge from any state, discard the result, and block acceptance in that cycle.
REQ-025 quotient and remainder SHALL be registered outputs, unchanged outside a DONE entry.

Reset
REQ-026 rst=1 at a rising edge SHALL set state=IDLE, out_valid=0, in_ready=1 on the following cycle, and quotient=0, remainder=0, iteration counter=0.
REQ-027 Reset mid-operation SHALL abandon the operation with no result ever presented.
REQ-028 rst SHALL take priority over flush, which SHALL take priority over acceptance.

Structure
REQ-029 The shared package SHALL hold the state encoding (IDLE/BUSY/DONE), XLEN, and the iteration-count constants 64 and 32.
REQ-030 The per-cycle shift-subtract step SHALL be one combinational sub-module, div_step (partial remainder, divisor, quotient in -> updated values out).
REQ-031 The FSM, iteration counter, sign fix-up and special-case detection SHALL live in div_unit.

Verification
REQ-032 Unsigned: 100 / 7, op_signed=0 -> out_valid 65 cycles after acceptance, quotient=14, remainder=2.
REQ-033 Signed: -7 / 2 -> quotient=0xFFFFFFFFFFFFFFFD, remainder=0xFFFFFFFFFFFFFFFF; 7 / -2 -> quotient=-3, remainder=1.
REQ-034 Specials: 5 / 0 -> next cycle quotient=0xFFFFFFFFFFFFFFFF, remainder=5; signed 0x8000000000000000 / -1 -> quotient=0x8000000000000000, remainder=0, next cycle.
REQ-035 Word: DIVW 0x0000000080000000 / 0xFFFFFFFFFFFFFFFF -> quotient=0xFFFFFFFF80000000, remainder=0; DIVUW 0xFFFFFFFF / 2 -> quotient=0x000000007FFFFFFF, remainder=1, out_valid 33 cycles after acceptance.
REQ-036 Control: flush at iteration 10 -> IDLE next cycle, no out_valid; out_ready held low 5 cycles in DONE -> outputs stable, IDLE one cycle after out_ready=1; rst mid-BUSY -> all outputs 0, in_ready=1.
